// File: rtl/seg_scan_counter_pkg.sv
// Shared types and active-low seven-segment patterns for seg_scan_counter.
// Segment order is {a,b,c,d,e,f,g}; a 0 bit lights the segment.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_scan_counter_if.sv
// Control/display bundle for seg_scan_counter.
// master: the side driving en/up/clr and watching the display (board / bench).
// slave:  the counter itself.
interface seg_scan_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  clr;
    logic [4*DIGITS-1:0]   value;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, up, clr,
        input  value, wrap, seg, an
    );

    modport slave (
        input  en, up, clr,
        output value, wrap, seg, an
    );
endinterface

// File: rtl/seg_bcd_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes 10..15 cannot occur in the counter but decode to blank for safety.
module seg_bcd_decode
    import seg_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup; default first so every path assigns seg_o.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed common-anode
// seven-segment scan. Two free-running dividers (count tick, digit scan)
// give single-cycle strobes; no derived clocks.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_counter_if.slave  bus_if
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                tick, scan;

    logic [4*DIGITS-1:0] value_q, value_d;
    logic                wrap_q, wrap_d;
    logic [4*DIGITS-1:0] inc_val, dec_val;
    logic                inc_carry, dec_borrow;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    bcd_t                cur_digit;
    logic [6:0]          cur_seg;
    logic                blank;

    // ---------------- dividers ----------------
    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign scan       = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign scan_cnt_d = scan ? '0 : scan_cnt_q + 1'b1;

    // Divider registers; they free-run and ignore en/clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    // ---------------- BCD arithmetic ----------------
    // Ripple increment and decrement candidates; a carry/borrow out of the
    // top digit is exactly the decimal wrap condition.
    always_comb begin
        inc_val    = value_q;
        dec_val    = value_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // Count next-state: clear beats tick, then up/down, else hold.
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (bus_if.clr) begin
            value_d = '0;
        end else if (tick && bus_if.en && bus_if.up) begin
            value_d = inc_val;
            wrap_d  = inc_carry;
        end else if (tick && bus_if.en) begin
            value_d = dec_val;
            wrap_d  = dec_borrow;
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    // ---------------- display scan ----------------
    assign cur_digit = value_q[4*idx_q +: 4];

    seg_bcd_decode u_decode (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lead_zero;
    logic              zero_run;

    // A digit is blanked when it and every digit above it are zero;
    // digit 0 is always shown.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (value_q[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    assign blank = lead_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    // One-hot-low anode pattern for the digit being latched this scan.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign an_d[gi] = (idx_q != IDX_W'(gi));
    end

    assign seg_d = blank ? SEG_BLANK : cur_seg;
    assign idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // Scan register: seg and an update together on each scan strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else if (scan) begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus_if.value = value_q;
    assign bus_if.wrap  = wrap_q;
    assign bus_if.seg   = seg_q;
    assign bus_if.an    = an_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Bench for seg_scan_counter with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
// Each count step pushes its expected value/wrap to a queue; the result is
// popped and compared once the step's tick edge has passed.
module tb_seg_scan_counter;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    typedef struct {
        logic [7:0] val;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_counter_if #(.DIGITS(DIGITS)) bus_if ();

    seg_scan_counter #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   m_val = 0;      // decimal model of the count, 0..99
    int   wrap_seen = 0;
    logic [6:0] seg_tab [10];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

    // Display check against the model value; assumes the value has been stable
    // for at least one full scan round.
    task automatic disp_check(input int n);
        logic [6:0] want_hi;
        want_hi = seg_tab[n / 10];
`ifdef SEG_SCAN_LZB_EN
        if (n / 10 == 0) want_hi = 7'b1111111;
`endif
        if (bus_if.an == 2'b10)
            check_val("seg_d0", {25'd0, bus_if.seg}, {25'd0, seg_tab[n % 10]});
        else if (bus_if.an == 2'b01)
            check_val("seg_d1", {25'd0, bus_if.seg}, {25'd0, want_hi});
        else
            check_val("an_onehot", {30'd0, bus_if.an}, 32'd2);
    endtask

    // One count step: TICK_DIV cycles starting just after a tick edge.
    task automatic do_step(input logic en_v, input logic up_v,
                           input logic clr_on_tick, input logic disp);
        exp_t e;
        logic [7:0] prev;
        prev = to_bcd(m_val);
        e.wrap = 1'b0;
        if (clr_on_tick) begin
            m_val = 0;
        end else if (en_v && up_v) begin
            if (m_val == 99) begin m_val = 0; e.wrap = 1'b1; end
            else m_val = m_val + 1;
        end else if (en_v) begin
            if (m_val == 0) begin m_val = 99; e.wrap = 1'b1; end
            else m_val = m_val - 1;
        end
        e.val = to_bcd(m_val);
        exp_q.push_back(e);

        bus_if.en  = en_v;
        bus_if.up  = up_v;
        bus_if.clr = 1'b0;
        for (int c = 0; c < TICK_DIV; c++) begin
            if (clr_on_tick && c == TICK_DIV - 1) bus_if.clr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (c < TICK_DIV - 1) begin
                check_val("hold", {24'd0, bus_if.value}, {24'd0, prev});
                check_val("wrap_idle", {31'd0, bus_if.wrap}, 32'd0);
                if (disp) disp_check(m_val);
            end
        end
        bus_if.clr = 1'b0;

        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("value", {24'd0, bus_if.value}, {24'd0, e.val});
            check_val("wrap", {31'd0, bus_if.wrap}, {31'd0, e.wrap});
            check_val("bcd", {31'd0, bcd_ok(bus_if.value)}, 32'd1);
            if (disp) disp_check(m_val);
            if (bus_if.wrap) wrap_seen++;
        end
        $display("step en=%b up=%b clr=%b value=%h wrap=%b", en_v, up_v, clr_on_tick,
                 bus_if.value, bus_if.wrap);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_value"}, {24'd0, bus_if.value}, 32'd0);
        check_val({tag, "_wrap"},  {31'd0, bus_if.wrap},  32'd0);
        check_val({tag, "_seg"},   {25'd0, bus_if.seg},   32'h7f);
        check_val({tag, "_an"},    {30'd0, bus_if.an},    32'd3);
    endtask

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        bus_if.en  = 1'b0;
        bus_if.up  = 1'b1;
        bus_if.clr = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        reset_checks("rst0");
        rst = 1'b0;
        m_val = 0;

        // Down from zero wraps to 99, then 98.
        do_step(1'b1, 1'b0, 1'b0, 1'b0);
        do_step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-count and mid-scan: takes effect without a clock edge.
        bus_if.up = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        m_val = 0;
        $display("reset applied mid-count");

        // Full up sweep 01..99,00 with exactly one wrap pulse.
        wrap_seen = 0;
        for (int i = 0; i < 100; i++) do_step(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("wrap_count", wrap_seen, 32'd1);

        // To 37, clear on the tick cycle, then freeze for 10 ticks.
        for (int i = 0; i < 37; i++) do_step(1'b1, 1'b1, 1'b0, 1'b0);
        do_step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) do_step(1'b0, 1'b1, 1'b0, 1'b0);

        // Value 05 on the display.
        for (int i = 0; i < 5; i++) do_step(1'b1, 1'b1, 1'b0, 1'b0);
        do_step(1'b0, 1'b1, 1'b0, 1'b0);
        do_step(1'b0, 1'b1, 1'b0, 1'b1);

        // Up to 19, then the 19 -> 20 carry.
        for (int i = 0; i < 14; i++) do_step(1'b1, 1'b1, 1'b0, 1'b0);
        do_step(1'b1, 1'b1, 1'b0, 1'b0);
        do_step(1'b0, 1'b1, 1'b0, 1'b0);
        do_step(1'b0, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
